// File: rtl/uart_tx_arbiter_if.sv
// IO-bus link between the TX arbiter (master) and uart_core (slave).
// Read data returns the cycle after a read strobe.
interface uart_tx_arbiter_if;
  logic        cs;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, rd_en, wr_en, address, wr_data, input rd_data);
  modport slave  (input cs, rd_en, wr_en, address, wr_data, output rd_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the uart_core TX FIFO between NUM_REQ
// byte streams; polls TX status for credits and writes one byte per cycle while credits last.
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] STATUS_ADDR = 8'h08,  // MMIO_UART_GET_STATUS offset
  parameter logic [7:0] DATA_ADDR   = 8'h04,  // MMIO_UART_WRITE_DATA offset
  parameter int         LOCK_TMO    = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  uart_tx_arbiter_if.master      io_bus_m,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(LOCK_TMO + 1);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST     = TW'(LOCK_TMO - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, POLL, WAIT, WRITE} state_e;

  state_e        state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_q;
  logic [CW-1:0] credits_q;
  logic [TW-1:0] idle_cnt_q;
  logic          lock_q;
  logic          busy_q;

  logic [7:0]         req_byte [NUM_REQ];
  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_byte;
  logic               wr_fire;
  logic [IW-1:0]      next_rr_d;
  logic [NUM_REQ-1:0] eligible;
  logic [IW-1:0]      scan_idx;
  logic               grant_found_d;
  logic [IW-1:0]      grant_idx_d;
  logic               tx_full;
  logic               tx_empty;
  logic [CW-1:0]      poll_credits_d;
  logic               unused_rd_bits;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = req_data[8*i +: 8];
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_byte  = req_byte[owner_q];
  assign next_rr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Scan downwards so the lowest offset from rr_q is the last (winning) assignment.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    eligible      = lock_q ? (NUM_REQ'(1) << owner_q) : '1;
    grant_found_d = 1'b0;
    grant_idx_d   = rr_q;
    scan_idx      = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[scan_idx] && eligible[scan_idx]) begin
        grant_found_d = 1'b1;
        grant_idx_d   = scan_idx;
      end
    end
  end

  assign tx_full        = io_bus_m.rd_data[3];
  assign tx_empty       = io_bus_m.rd_data[2];
  assign unused_rd_bits = ^{io_bus_m.rd_data[31:4], io_bus_m.rd_data[1:0]};
  assign poll_credits_d = tx_empty ? FULL_CREDITS : (!tx_full ? CW'(1) : '0);

  // The write strobe must coincide with the accept pulse to sustain one byte per cycle,
  // so it is decoded from the registered state and the owner's live valid.
  assign wr_fire = (state_q == WRITE) && owner_valid && (credits_q != '0);

  assign io_bus_m.rd_en   = (state_q == POLL);
  assign io_bus_m.wr_en   = wr_fire;
  assign io_bus_m.cs      = (state_q == POLL) || wr_fire;
  assign io_bus_m.address = {24'h0, (state_q == POLL) ? STATUS_ADDR :
                                    (wr_fire ? DATA_ADDR : 8'h00)};
  assign io_bus_m.wr_data = {24'h0, wr_fire ? owner_byte : 8'h00};
  assign req_ready        = wr_fire ? (NUM_REQ'(1) << owner_q) : '0;
  assign grant_id         = 3'(owner_q);
  assign busy             = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      credits_q  <= '0;
      idle_cnt_q <= '0;
      lock_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found_d) begin
            owner_q    <= grant_idx_d;
            busy_q     <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= (credits_q != '0) ? WRITE : POLL;
          end
        end
        POLL: state_q <= WAIT;
        WAIT: begin
          credits_q <= poll_credits_d;
          state_q   <= (poll_credits_d != '0) ? WRITE : POLL;
        end
        WRITE: begin
          if (wr_fire) begin
            credits_q  <= credits_q - 1'b1;
            idle_cnt_q <= '0;
            if (owner_last) begin
              lock_q  <= 1'b0;
              busy_q  <= 1'b0;
              rr_q    <= next_rr_d;
              state_q <= IDLE;
            end else begin
              lock_q <= 1'b1;
              if (credits_q == CW'(1)) state_q <= POLL;
            end
          end else if (credits_q == '0) begin
            state_q <= POLL;
          end else if (idle_cnt_q == TMO_LAST) begin
            // Owner stalled mid-packet too long: give the port to the others.
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
            rr_q       <= next_rr_d;
            idle_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart_core status model
// driven on the falling edge, bus activity logged one time unit later.
module tb_uart_tx_arbiter;

  localparam int         NR          = 4;
  localparam int         FIFO_DEPTH  = 8;
  localparam logic [7:0] STATUS_ADDR = 8'h08;
  localparam logic [7:0] DATA_ADDR   = 8'h04;
  localparam int         LOCK_TMO    = 255;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [2:0]      grant_id;
  logic            busy;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STATUS_ADDR (STATUS_ADDR),
    .DATA_ADDR   (DATA_ADDR),
    .LOCK_TMO    (LOCK_TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .io_bus_m  (bus),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cyc;
    logic [2:0] gid;
  } wr_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]    rq_mem [NR][64];
  int            rq_head [NR];
  int            rq_tail [NR];
  logic [NR-1:0] fired = '0;
  logic          rd_pend = 1'b0;
  logic [31:0]   rd_val = '0;
  logic          status_full  = 1'b0;
  logic          status_empty = 1'b1;
  int            cyc = 0;
  int            poll_cnt = 0;
  int            last_poll_cyc = 0;
  int            prev_poll_cyc = 0;
  int            viol = 0;
  wr_t           wr_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int log_id(input int k);
    return (k < wr_log.size()) ? wr_log[k].id : -2;
  endfunction

  function automatic logic [7:0] log_data(input int k);
    return (k < wr_log.size()) ? wr_log[k].data : 8'hxx;
  endfunction

  function automatic int log_cyc(input int k);
    return (k < wr_log.size()) ? wr_log[k].cyc : -1000;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic last);
    rq_mem[r][rq_tail[r]] = {last, d};
    rq_tail[r]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] < rq_tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        req_last[i]        = rq_mem[i][rq_head[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic sample_bus();
    wr_t e;
    int  id;
    if ($countones(req_ready) > 1) viol++;
    if (bus.rd_en && bus.wr_en) viol++;
    if (bus.cs != (bus.rd_en || bus.wr_en)) viol++;
    if ((req_ready != '0) && !(bus.cs && bus.wr_en)) viol++;
    fired = req_ready & req_valid;
    if (bus.wr_en) begin
      id = -1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) id = i;
      if (id < 0 || bus.address !== {24'h0, DATA_ADDR}) viol++;
      e.id   = id;
      e.data = bus.wr_data[7:0];
      e.cyc  = cyc;
      e.gid  = grant_id;
      wr_log.push_back(e);
    end
    if (bus.rd_en) begin
      if (bus.address !== {24'h0, STATUS_ADDR}) viol++;
      poll_cnt++;
      prev_poll_cyc = last_poll_cyc;
      last_poll_cyc = cyc;
      rd_pend = 1'b1;
      rd_val  = {28'h0, status_full, status_empty, 2'b00};
    end
  endtask

  // Requester and uart_core model: update on the falling edge, observe 1 unit later.
  initial begin
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NR; i++)
        if (fired[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
      fired       = '0;
      bus.rd_data = rd_pend ? rd_val : 32'h0;
      rd_pend     = 1'b0;
      drive_reqs();
      #1;
      sample_bus();
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) rq_head[i] = rq_tail[i];
    fired = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_writes(input string tag, input int n, input int max_cyc);
    int k;
    k = 0;
    while (wr_log.size() < n && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    check(tag, wr_log.size(), n);
  endtask

  initial begin
    int         wb;
    int         pb;
    int         k;
    logic [7:0] t1_exp [3];
    int         t2_id  [6];
    logic [7:0] t2_dat [6];

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy",    busy, 0);
    check("rst_grant",   grant_id, 0);
    check("rst_cs",      bus.cs, 0);
    check("rst_strobes", {bus.rd_en, bus.wr_en}, 0);
    check("rst_ready",   req_ready, 0);
    check("rst_addr",    bus.address, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("idle_cs",   bus.cs, 0);
    check("idle_busy", busy, 0);

    // Single 3-byte packet from req0, FIFO empty
    t1_exp = '{8'hA1, 8'hA2, 8'hA3};
    wb = wr_log.size();
    pb = poll_cnt;
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b0);
    push(0, 8'hA3, 1'b1);
    wait_writes("t1_writes", wb + 3, 40);
    @(negedge clk);
    #2;
    check("t1_busy_released", busy, 0);
    check("t1_polls", poll_cnt - pb, 1);
    for (int i = 0; i < 3; i++) begin
      check("t1_id",   log_id(wb + i), 0);
      check("t1_data", log_data(wb + i), t1_exp[i]);
    end
    check("t1_b2b_1", log_cyc(wb + 1) - log_cyc(wb), 1);
    check("t1_b2b_2", log_cyc(wb + 2) - log_cyc(wb + 1), 1);
    check("t1_gid", (wb < wr_log.size()) ? wr_log[wb].gid : 3'h7, 0);

    // req0 and req2 with 1-byte packets alternate from a fresh rr pointer
    do_reset();
    t2_id  = '{0, 2, 0, 2, 0, 2};
    t2_dat = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    wb = wr_log.size();
    pb = poll_cnt;
    for (int i = 0; i < 3; i++) begin
      push(0, 8'h10 + 8'(i), 1'b1);
      push(2, 8'h20 + 8'(i), 1'b1);
    end
    wait_writes("t2_writes", wb + 6, 60);
    for (int i = 0; i < 6; i++) begin
      check("t2_order", log_id(wb + i), t2_id[i]);
      check("t2_data",  log_data(wb + i), t2_dat[i]);
    end
    check("t2_polls", poll_cnt - pb, 1);

    // req1 5-byte packet (crosses a credit refill) is not interleaved with req3
    wb = wr_log.size();
    pb = poll_cnt;
    for (int i = 0; i < 5; i++) push(1, 8'h30 + 8'(i), (i == 4));
    wait_writes("t3_first", wb + 1, 20);
    push(3, 8'h40, 1'b0);
    push(3, 8'h41, 1'b1);
    wait_writes("t3_writes", wb + 7, 60);
    for (int i = 0; i < 7; i++) check("t3_order", log_id(wb + i), (i < 5) ? 1 : 3);
    check("t3_last_b1", log_data(wb + 4), 8'h34);
    check("t3_last_b3", log_data(wb + 6), 8'h41);
    check("t3_polls", poll_cnt - pb, 1);

    // TX FIFO full for 10 polls, then empty
    do_reset();
    status_full  = 1'b1;
    status_empty = 1'b0;
    wb = wr_log.size();
    pb = poll_cnt;
    push(0, 8'h50, 1'b0);
    push(0, 8'h51, 1'b1);
    k = 0;
    while ((poll_cnt - pb) < 10 && k < 60) begin
      @(posedge clk);
      k++;
    end
    check("t4_full_polls", poll_cnt - pb, 10);
    check("t4_no_write_full", wr_log.size() - wb, 0);
    check("t4_poll_period", last_poll_cyc - prev_poll_cyc, 2);
    check("t4_busy_full", busy, 1);
    status_full  = 1'b0;
    status_empty = 1'b1;
    wait_writes("t4_writes", wb + 2, 20);
    check("t4_polls_total", poll_cnt - pb, 11);
    check("t4_id0", log_id(wb), 0);
    check("t4_d0",  log_data(wb), 8'h50);
    check("t4_d1",  log_data(wb + 1), 8'h51);

    // Locked owner goes quiet; lock times out and req2 is granted
    wb = wr_log.size();
    push(1, 8'h60, 1'b0);
    wait_writes("t5_first", wb + 1, 20);
    push(2, 8'h70, 1'b1);
    repeat (100) @(negedge clk);
    #2;
    check("t5_locked_busy",  busy, 1);
    check("t5_locked_owner", grant_id, 1);
    check("t5_no_steal", wr_log.size() - wb, 1);
    wait_writes("t5_second", wb + 2, LOCK_TMO + 20);
    check("t5_new_owner", log_id(wb + 1), 2);
    check("t5_new_data",  log_data(wb + 1), 8'h70);
    check("t5_tmo_gap", log_cyc(wb + 1) - log_cyc(wb), LOCK_TMO + 2);
    @(negedge clk);
    #2;
    check("t5_released", busy, 0);

    // Asynchronous reset in the middle of a req3 packet
    wb = wr_log.size();
    push(3, 8'h80, 1'b0);
    push(3, 8'h81, 1'b0);
    push(3, 8'h82, 1'b1);
    wait_writes("t6_first", wb + 1, 20);
    @(negedge clk);
    #2;
    check("t6_mid_write", bus.wr_en, 1);
    check("t6_mid_owner", grant_id, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_cs",    bus.cs, 0);
    check("t6_rst_wr",    bus.wr_en, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_busy",  busy, 0);
    check("t6_rst_grant", grant_id, 0);
    do_reset();
    wb = wr_log.size();
    push(0, 8'h90, 1'b1);
    push(3, 8'h91, 1'b1);
    wait_writes("t6_writes", wb + 2, 30);
    check("t6_first_req0",  log_id(wb), 0);
    check("t6_second_req3", log_id(wb + 1), 3);
    check("t6_data3", log_data(wb + 1), 8'h91);

    check("protocol_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
